// File: rtl/keypad_emulator.sv
// keypad_emulator: scripted 4x4 matrix keypad returning col for the scanner's one-hot rows drive.
// Define KEYPAD_EMU_BOUNCE_EN to add contact-bounce windows around each press and release.
module keypad_emulator #(
  parameter int BOUNCE_CYCLES = 32,
  parameter int BOUNCE_PERIOD = 4,
  parameter int GAP_CYCLES    = 400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows,
  output logic [3:0]  col,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] key_hold,
  output logic        key_ready,
  output logic        busy,
  output logic        done
);
`ifdef KEYPAD_EMU_BOUNCE_EN
  typedef enum logic [2:0] {IDLE, B_PRESS, HOLD, B_REL, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
`endif
  state_t state, state_d;
  logic [3:0] code;
  logic [15:0] cnt, hold_len;
  logic contact;
`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [15:0] hold_q;
  logic [7:0] bcnt, pcnt;
  logic phase;
  assign hold_len = hold_q == 16'd0 ? 16'd1 : hold_q;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = key_valid ? B_PRESS : IDLE;
      B_PRESS: state_d = bcnt == 8'd1 ? HOLD : B_PRESS;
      HOLD:    state_d = cnt == 16'd1 ? B_REL : HOLD;
      B_REL:   state_d = bcnt == 8'd1 ? GAP : B_REL;
      GAP:     state_d = cnt == 16'd1 ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  always_comb contact = (state == HOLD) | (state == B_PRESS & phase) | (state == B_REL & ~phase);
  // Bounce window and toggle period are reloaded on every entry to a bounce state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q <= '0;
      bcnt   <= '0;
      pcnt   <= '0;
      phase  <= 1'b0;
    end else begin
      if (state == IDLE && key_valid) hold_q <= key_hold;
      if (state_d != state && (state_d == B_PRESS || state_d == B_REL)) begin
        bcnt  <= 8'(BOUNCE_CYCLES);
        pcnt  <= 8'(BOUNCE_PERIOD);
        phase <= 1'b1;
      end else if (state == B_PRESS || state == B_REL) begin
        bcnt  <= bcnt - 8'd1;
        pcnt  <= pcnt == 8'd1 ? 8'(BOUNCE_PERIOD) : pcnt - 8'd1;
        phase <= pcnt == 8'd1 ? ~phase : phase;
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{8'(BOUNCE_CYCLES), 8'(BOUNCE_PERIOD)};
  assign hold_len = key_hold == 16'd0 ? 16'd1 : key_hold;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = key_valid ? HOLD : IDLE;
      HOLD:    state_d = cnt == 16'd1 ? GAP : HOLD;
      GAP:     state_d = cnt == 16'd1 ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  always_comb contact = state == HOLD;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      code  <= '0;
      cnt   <= '0;
      col   <= '0;
    end else begin
      state <= state_d;
      col   <= contact ? ({4{rows[code[3:2]]}} & (4'b0001 << code[1:0])) : 4'b0000;
      if (state == IDLE && key_valid) code <= key_code;
      if (state_d != state) cnt <= state_d == HOLD ? hold_len : state_d == GAP ? 16'(GAP_CYCLES) : 16'd0;
      else if (cnt != 16'd0) cnt <= cnt - 16'd1;
    end
  end
  assign key_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign done      = state == GAP && cnt == 16'd1;
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed checks of col timing, handshake, done pulse and reset for keypad_emulator.
module tb_keypad_emulator;
  logic clk = 1'b0, reset = 1'b0, key_valid = 1'b0;
  logic key_ready, busy, done, saw_done;
  logic [3:0] rows = '0, col, key_code = '0;
  logic [15:0] key_hold = '0;
  int checks = 0, errors = 0;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int BW = 32;
`else
  localparam int BW = 0;
`endif
  localparam int BP = 4, GAP = 400;
  always #5 clk = ~clk;
  keypad_emulator dut (
    .clk(clk), .reset(reset), .rows(rows), .col(col), .key_valid(key_valid),
    .key_code(key_code), .key_hold(key_hold), .key_ready(key_ready), .busy(busy), .done(done)
  );
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Expected contact level k cycles after the acceptance edge.
  function automatic bit ec(input int k, input int h);
    if (k < BW) return ((k / BP) % 2) == 0;
    if (k < BW + h) return 1'b1;
    if (k < 2 * BW + h) return ((k - BW - h) / BP) % 2 == 1;
    return 1'b0;
  endfunction
  task automatic press(input logic [3:0] c, input logic [15:0] hold, input logic [3:0] r,
                       input logic [3:0] on, input bit pend);
    int h;
    int total;
    h = hold == 16'd0 ? 1 : int'(hold);
    total = 2 * BW + h + GAP;
    rows = r;
    key_code = c;
    key_hold = hold;
    key_valid = 1'b1;
    @(posedge clk); #1;
    check("accept_busy", {15'd0, busy}, 16'd1);
    check("accept_ready", {15'd0, key_ready}, 16'd0);
    key_valid = 1'b0;
    key_code = ~c;
    key_hold = 16'hffff;
    for (int j = 1; j <= total; j++) begin
      if (pend && j == 2) begin
        key_valid = 1'b1;
        key_code = 4'b0101;
        key_hold = 16'd3;
      end
      @(posedge clk); #1;
      check("col", {12'd0, col}, {12'd0, ec(j - 1, h) ? on : 4'b0000});
      check("done", {15'd0, done}, {15'd0, j == total - 1});
      check("ready", {15'd0, key_ready}, {15'd0, j == total});
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_col", {12'd0, col}, 16'd0);
    check("rst_ready", {15'd0, key_ready}, 16'd1);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rows = 4'b0001 << (i % 4);
      @(posedge clk); #1;
      check("idle_col", {12'd0, col}, 16'd0);
      check("idle_ready", {15'd0, key_ready}, 16'd1);
      check("idle_busy", {15'd0, busy}, 16'd0);
    end
    press(4'b1001, 16'd100, 4'b0100, 4'b0010, 1'b0);
    press(4'b1001, 16'd100, 4'b1011, 4'b0000, 1'b0);
    press(4'b0000, 16'd5, 4'b0001, 4'b0001, 1'b0);
    rows = 4'b0001;
    key_code = 4'b0000;
    key_hold = 16'd50;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (BW + 5) @(posedge clk);
    #1;
    check("hold_col", {12'd0, col}, 16'h0001);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_col", {12'd0, col}, 16'd0);
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    check("mid_rst_ready", {15'd0, key_ready}, 16'd1);
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (600) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("no_done", {15'd0, saw_done}, 16'd0);
    check("post_rst_ready", {15'd0, key_ready}, 16'd1);
    press(4'b0000, 16'd0, 4'b0001, 4'b0001, 1'b1);
    press(4'b0101, 16'd3, 4'b0011, 4'b0010, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
